// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART constants and receiver state encodings.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int SOC_CLK_HZ        = 10_000_000;
    localparam int BAUD              = 115200;
    // Rounded to nearest: 10 MHz / 115200 -> 87
    localparam int CLKS_PER_BIT_DFLT = (SOC_CLK_HZ + BAUD / 2) / BAUD;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Single-clock first-word-fall-through FIFO with occupancy output.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_wr;
    logic             w_rd;

    // Extra MSB on each pointer separates the full and empty cases
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_rd    = i_rd_en && !w_empty;
    assign w_wr    = i_wr_en && (!w_full || w_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wr_data;
    end

    assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_level   = r_wr_ptr - r_rd_ptr;

endmodule
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_fifo
// Brief    : 8N1 UART receiver with input synchroniser and receive FIFO.
// Revision : 1.0
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT,
    parameter int FIFO_DEPTH   = 8,
    parameter int FIFO_AW      = 3
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   rx_i,
    output logic [UART_DATA_W-1:0] data_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [FIFO_AW:0]       level_o,
    output logic                   frame_err_o,
    output logic                   overrun_o,
    output logic                   busy_o
);

    localparam int                 c_CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MID  = c_CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic                   r_rx_meta;
    logic                   r_rx_s;
    rx_state_t              r_state;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [2:0]             r_idx;
    logic [UART_DATA_W-1:0] r_shift;
    logic                   r_frame_err;
    logic                   r_overrun;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_stop_tick;
    logic                   w_push;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_s    <= r_rx_meta;
        end
    end

    assign w_pop       = !w_empty && ready_i;
    assign w_stop_tick = (r_state == ST_STOP) && (r_cnt == c_CNT_LAST);
    // A simultaneous pop frees a slot, so a full FIFO can still accept
    assign w_push      = w_stop_tick && r_rx_s && (!w_full || w_pop);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                    end
                end
                ST_START: begin
                    if (r_cnt == c_CNT_MID) begin
                        r_cnt <= '0;
                        if (!r_rx_s) begin
                            r_state <= ST_DATA;
                            r_idx   <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_s, r_shift[UART_DATA_W-1:1]};
                        if (r_idx == 3'd7) r_state <= ST_STOP;
                        else               r_idx   <= r_idx + 3'd1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_overrun <= w_full && !w_pop;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (r_rx_s) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (UART_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .i_wr_en   (w_push),
        .i_wr_data (r_shift),
        .i_rd_en   (ready_i),
        .o_rd_data (data_o),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_level   (level_o)
    );

    assign valid_o     = !w_empty;
    assign busy_o      = (r_state != ST_IDLE);
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_fifo
// Brief    : Directed self-checking bench for uart_rx_fifo.
// Revision : 1.0
// ============================================================================
module tb_uart_rx_fifo;

    localparam int CPB = 87;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;
    logic [3:0] level_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic       busy_o;

    int n_checks = 0;
    int n_err    = 0;
    int n_fe     = 0;
    int n_ov     = 0;
    int n_both   = 0;
    int fe0;
    int ov0;

    uart_rx_fifo u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .level_o     (level_o),
        .frame_err_o (frame_err_o),
        .overrun_o   (overrun_o),
        .busy_o      (busy_o)
    );

    always #50 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (frame_err_o === 1'b1) n_fe++;
        if (overrun_o === 1'b1)   n_ov++;
        if (frame_err_o === 1'b1 && overrun_o === 1'b1) n_both++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Called #1 after a clock edge; returns #1 after the edge ending the stop bit
    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx_i = 1'b0;
        repeat (CPB) @(posedge clk_i);
        #1;
        for (int k = 0; k < 8; k++) begin
            rx_i = b[k];
            repeat (CPB) @(posedge clk_i);
            #1;
        end
        rx_i = stop_bit;
        repeat (CPB) @(posedge clk_i);
        #1;
    endtask

    task automatic pop_one();
        ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        ready_i = 1'b0;
    endtask

    initial begin
        rst_i   = 1'b1;
        rx_i    = 1'b1;
        ready_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #1;
        chk("rst_valid", valid_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_fe", frame_err_o, 0);
        chk("rst_ov", overrun_o, 0);
        rst_i = 1'b0;
        repeat (2000) @(posedge clk_i);
        #1;
        chk("idle_valid", valid_o, 0);
        chk("idle_busy", busy_o, 0);
        chk("idle_fe_cnt", n_fe, 0);
        chk("idle_ov_cnt", n_ov, 0);

        // Single byte latency: valid_o rises 829 edges after the start edge
        fork
            send_byte(8'h55, 1'b1);
            begin
                repeat (828) @(posedge clk_i);
                #1;
                chk("lat_valid_early", valid_o, 0);
                chk("lat_busy", busy_o, 1);
                @(posedge clk_i);
                #1;
                chk("lat_valid", valid_o, 1);
                chk("lat_data", data_o, 8'h55);
                chk("lat_level", level_o, 1);
            end
        join
        pop_one();
        chk("single_pop_valid", valid_o, 0);
        chk("single_pop_level", level_o, 0);

        // Ten back-to-back bytes into an 8-deep FIFO
        ov0 = n_ov;
        for (int i = 0; i < 10; i++) send_byte(8'(i), 1'b1);
        chk("b2b_level", level_o, 8);
        chk("b2b_overruns", n_ov - ov0, 2);
        for (int i = 0; i < 8; i++) begin
            chk("b2b_drain", data_o, i);
            pop_one();
        end
        chk("b2b_empty", valid_o, 0);

        // Full FIFO with a pop coinciding with the stop sample
        for (int i = 0; i < 8; i++) send_byte(8'(16 + i), 1'b1);
        chk("full_level", level_o, 8);
        ov0 = n_ov;
        fork
            send_byte(8'h18, 1'b1);
            begin
                repeat (828) @(posedge clk_i);
                #1;
                ready_i = 1'b1;
                chk("fullpop_pre_level", level_o, 8);
                @(posedge clk_i);
                #1;
                ready_i = 1'b0;
                chk("fullpop_level", level_o, 8);
            end
        join
        chk("fullpop_no_ov", n_ov - ov0, 0);
        for (int i = 0; i < 8; i++) begin
            chk("fullpop_drain", data_o, 17 + i);
            pop_one();
        end
        chk("fullpop_empty", valid_o, 0);

        // Framing error followed by a held-low line
        fe0 = n_fe;
        send_byte(8'hA5, 1'b0);
        repeat (3000) @(posedge clk_i);
        #1;
        chk("fe_count", n_fe - fe0, 1);
        chk("fe_busy_break", busy_o, 1);
        chk("fe_no_push", level_o, 0);
        rx_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        chk("fe_busy_released", busy_o, 0);
        chk("fe_count_after", n_fe - fe0, 1);
        send_byte(8'h3C, 1'b1);
        chk("fe_next_valid", valid_o, 1);
        chk("fe_next_data", data_o, 8'h3C);
        chk("fe_next_level", level_o, 1);

        // 20-cycle glitch on the line
        fe0 = n_fe;
        rx_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        chk("glitch_busy", busy_o, 1);
        repeat (10) @(posedge clk_i);
        #1;
        rx_i = 1'b1;
        repeat (100) @(posedge clk_i);
        #1;
        chk("glitch_idle", busy_o, 0);
        chk("glitch_level", level_o, 1);
        chk("glitch_data", data_o, 8'h3C);
        chk("glitch_no_fe", n_fe - fe0, 0);

        // Reset in the middle of 0x7E, held until the frame has passed
        fork
            send_byte(8'h7E, 1'b1);
            begin
                repeat (299) @(posedge clk_i);
                #1;
                chk("midrst_busy", busy_o, 1);
                chk("midrst_level_pre", level_o, 1);
                rst_i = 1'b1;
                repeat (600) @(posedge clk_i);
                #1;
                rst_i = 1'b0;
            end
        join
        chk("midrst_level", level_o, 0);
        chk("midrst_valid", valid_o, 0);
        chk("midrst_busy_after", busy_o, 0);
        chk("midrst_data", data_o, 0);
        send_byte(8'h81, 1'b1);
        chk("post_rst_valid", valid_o, 1);
        chk("post_rst_data", data_o, 8'h81);
        chk("post_rst_level", level_o, 1);
        pop_one();
        chk("post_rst_empty", valid_o, 0);
        chk("flags_exclusive", n_both, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
